// File: rtl/addsub_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder/subtractor.
// The b-field helpers size and place the not-yet-consumed B chunks that each stage forwards.
package addsub_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic int calc_cw(input int width, input int stages);
      return (stages > 0) ? width / stages : width;
   endfunction

   function automatic bit params_ok(input int width, input int stages);
      return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

   // Stage k (k >= 1) holds B chunks k..stages-1; the fields are packed back to back.
   function automatic int b_field_off(input int stages, input int cw, input int k);
      int off;
      off = 0;
      for (int j = 1; j < k; j++) begin
         off += (stages - j) * cw;
      end
      return off;
   endfunction

endpackage

// File: rtl/addsub_stage.sv
// One registered chunk of the carry chain: sums its chunk operands plus the incoming
// carry and holds everything, valid included, while adv is low.
module addsub_stage
#(
   parameter int CW = 2
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          adv,
   input  logic          valid_i,
   input  logic [CW-1:0] a_i,
   input  logic [CW-1:0] b_i,
   input  logic          c_i,
   output logic          valid_o,
   output logic [CW-1:0] sum_o,
   output logic          c_o,
   output logic          c_msb_o
);

   logic [CW:0]   total;
   logic          valid_d, valid_q;
   logic [CW-1:0] sum_d, sum_q;
   logic          c_d, c_q;
   logic          c_msb_d, c_msb_q;

   always_comb begin
      total   = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, c_i};
      valid_d = valid_q;
      sum_d   = sum_q;
      c_d     = c_q;
      c_msb_d = c_msb_q;
      if (adv) begin
         valid_d = valid_i;
         sum_d   = total[CW-1:0];
         c_d     = total[CW];
         // carry into the chunk MSB, recovered from the MSB sum bit
         c_msb_d = a_i[CW-1] ^ b_i[CW-1] ^ total[CW-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         sum_q   <= '0;
         c_q     <= 1'b0;
         c_msb_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         sum_q   <= sum_d;
         c_q     <= c_d;
         c_msb_q <= c_msb_d;
      end
   end

   assign valid_o = valid_q;
   assign sum_o   = sum_q;
   assign c_o     = c_q;
   assign c_msb_o = c_msb_q;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor, STAGES registered carry chunks, valid/ready flow
// with a single global advance. Outputs come straight from the last stage registers.
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 4
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = calc_cw(WIDTH, STAGES);
   localparam int RW = (STAGES > 1) ? WIDTH - CW : 1;
   localparam int BW = (STAGES > 1) ? b_field_off(STAGES, CW, STAGES) : 1;

   if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
      $error("pipelined_addsub: illegal WIDTH/STAGES combination");
   end

   logic                         adv;
   logic [WIDTH-1:0]             b_eff;
   logic [STAGES:0]              valid;
   logic [STAGES:0]              carry;
   logic [STAGES-1:0]            c_msb;
   logic [STAGES:0][WIDTH-1:0]   a_field;
   logic [STAGES-1:0][CW-1:0]    b_chunk;
   logic [STAGES-1:0][CW-1:0]    sum;
   logic [STAGES-1:0][RW-1:0]    rest_nxt, rest_d, rest_q;
   logic [BW-1:0]                b_rem_nxt, b_rem_d, b_rem_q;

   assign adv        = !valid[STAGES] || out_ready;
   assign b_eff      = (sub == MODE_SUB) ? ~b : b;
   assign carry[0]   = cin ^ sub;
   assign valid[0]   = in_valid;
   assign a_field[0] = a;

   // a_field[k] = {sums of stages k-1..0, A chunks still to be consumed}; the low chunk feeds stage k
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_b_first
         assign b_chunk[k] = b_eff[CW-1:0];
      end else begin : g_b_rest
         assign b_chunk[k] = b_rem_q[b_field_off(STAGES, CW, k) +: CW];
      end

      if (k == 1) begin : g_b_load
         assign b_rem_nxt[0 +: (STAGES-1)*CW] = b_eff[WIDTH-1:CW];
      end else if (k > 1) begin : g_b_shift
         assign b_rem_nxt[b_field_off(STAGES, CW, k) +: (STAGES-k)*CW] =
            b_rem_q[b_field_off(STAGES, CW, k-1) + CW +: (STAGES-k)*CW];
      end

      if (STAGES > 1) begin : g_field
         assign rest_nxt[k]  = a_field[k][WIDTH-1:CW];
         assign a_field[k+1] = {sum[k], rest_q[k]};
      end else begin : g_field_single
         assign a_field[k+1] = sum[k];
      end

      addsub_stage #(.CW(CW)) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .adv     (adv),
         .valid_i (valid[k]),
         .a_i     (a_field[k][CW-1:0]),
         .b_i     (b_chunk[k]),
         .c_i     (carry[k]),
         .valid_o (valid[k+1]),
         .sum_o   (sum[k]),
         .c_o     (carry[k+1]),
         .c_msb_o (c_msb[k])
      );
   end

   if (STAGES == 1) begin : g_no_fields
      assign rest_nxt  = '0;
      assign b_rem_nxt = '0;
   end

   always_comb begin
      rest_d  = rest_q;
      b_rem_d = b_rem_q;
      if (adv) begin
         rest_d  = rest_nxt;
         b_rem_d = b_rem_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rest_q  <= '0;
         b_rem_q <= '0;
      end else begin
         rest_q  <= rest_d;
         b_rem_q <= b_rem_d;
      end
   end

   assign in_ready  = adv;
   assign out_valid = valid[STAGES];
   assign result    = a_field[STAGES];
   assign cout      = carry[STAGES];
   assign ovf       = c_msb[STAGES-1] ^ carry[STAGES];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed and randomised checks of pipelined_addsub at WIDTH=8, STAGES=4.
module tb_pipelined_addsub;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       sub;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       cout;
   logic       ovf;

   int n_tests = 0;
   int n_fail  = 0;

   pipelined_addsub #(.WIDTH(8), .STAGES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {ovf, cout, result}
   function automatic logic [9:0] model(input logic [7:0] ta, input logic [7:0] tb,
                                        input logic tc, input logic ts);
      logic [7:0] be;
      logic       c0;
      logic [8:0] s;
      logic       o;
      be = ts ? ~tb : tb;
      c0 = ts ? ~tc : tc;
      s  = {1'b0, ta} + {1'b0, be} + {8'd0, c0};
      o  = (ta[7] == be[7]) && (s[7] != ta[7]);
      return {o, s[8], s[7:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic ts,
                        input logic [7:0] er, input logic ec, input logic eo);
      int lat;
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      chk({tag, " latency"}, lat, 4);
      chk({tag, " result"}, result, er);
      chk({tag, " cout"}, cout, ec);
      chk({tag, " ovf"}, ovf, eo);
      step();
   endtask

   logic [9:0] q[$];
   logic [9:0] exp_v;
   logic [7:0] held;
   int sent, got, stall_left, seen;
   bit stalled;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      #12;
      chk("reset out_valid", out_valid, 0);
      chk("reset result", result, 0);
      chk("reset in_ready", in_ready, 1);
      rst_n = 1'b1;
      step();

      // reset in the middle of a stream
      for (int i = 0; i < 6; i++) begin
         a = 8'(i + 1); b = 8'(i + 2); in_valid = 1'b1;
         step();
      end
      chk("pre-reset out_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("mid reset out_valid", out_valid, 0);
      chk("mid reset result", result, 0);
      chk("mid reset cout", cout, 0);
      chk("mid reset ovf", ovf, 0);
      chk("mid reset in_ready", in_ready, 1);
      step();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_valid) seen++;
      end
      chk("no output after reset", seen, 0);

      do_op("add 0f+01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
      do_op("add 7f+01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      do_op("add ff+01+1", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
      do_op("sub 00-01", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
      do_op("sub 80-01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

      // back-to-back stream with a 3-cycle stall on the first result
      sent = 0; got = 0; stall_left = 0; stalled = 1'b0; held = '0;
      cin = 1'b0; sub = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
         in_valid = (sent < 6);
         a = 8'(sent); b = 8'(2 * sent);
         if (out_valid && !stalled) begin
            stalled = 1'b1; stall_left = 3; held = result;
         end
         out_ready = (stall_left == 0);
         #1;
         if (out_valid && !out_ready) begin
            chk("bp in_ready", in_ready, 0);
            chk("bp hold", result, held);
            stall_left--;
         end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            chk("bp result", result, 3 * got);
            got++;
         end
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("bp count", got, 6);
      chk("bp stalled", stalled, 1);
      step(); step();
      chk("bp no duplicate", out_valid, 0);

      // random operands, modes and backpressure
      sent = 0; got = 0; q.delete();
      for (int cyc = 0; cyc < 20000 && (sent < 1000 || q.size() > 0); cyc++) begin
         in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         a         = 8'($urandom);
         b         = 8'($urandom);
         cin       = 1'($urandom);
         sub       = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("rnd spurious", out_valid, 0);
            end else begin
               exp_v = q.pop_front();
               chk("rnd result", {ovf, cout, result}, exp_v);
               got++;
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin, sub));
            sent++;
         end
         step();
      end
      in_valid = 1'b0;
      chk("rnd sent", sent, 1000);
      chk("rnd received", got, 1000);
      chk("rnd drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
